div_repeated_sub: RTL and testbench
===================================

# div_repeated_sub

Unsigned integer divider using repeated subtraction, the inverse of the repeated-addition multiplier datapath. Operands are loaded over a single shared data bus in two consecutive cycles: dividend first, then divisor. The block then subtracts the divisor from a running remainder once per cycle and counts the subtractions. It reports quotient, remainder and a divide-by-zero flag with a start/done handshake.

## Interface
- WIDTH, 16, operand, quotient and remainder width in bits
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; sampled only in IDLE or DONE
- din  input  WIDTH  operand bus; dividend on the start cycle, divisor on the following cycle
- quotient  output  WIDTH  result quotient, valid while done=1
- remainder  output  WIDTH  result remainder, valid while done=1
- busy  output  1  high from the cycle after start is accepted until done rises
- done  output  1  level; high in DONE until the next accepted start or reset
- dz  output  1  divide-by-zero flag, valid while done=1

## Operation
- States: IDLE, LDB, SUB, DONE.
- IDLE, start=1:
  - dividend register (the remainder register) <= din
  - quotient <= 0, dz <= 0
  - next state LDB
- LDB: divisor register <= din unconditionally. Next state:
  - DONE, if din==0; set dz=1, quotient <= all ones, remainder keeps the dividend
  - SUB otherwise
- SUB, each cycle:
  - if remainder >= divisor: remainder <= remainder − divisor, quotient <= quotient + 1, stay in SUB
  - else: next state DONE, registers unchanged
- DONE: outputs hold. start=1 behaves exactly as in IDLE: done drops, dividend is captured, next state LDB.
- start in LDB or SUB is ignored. No queuing, no effect on the operation in progress.
- Arithmetic:
  - unsigned compare and subtract at WIDTH bits
  - quotient never exceeds the dividend, so the quotient counter cannot overflow
- Reset (rst_n=0, any time, including mid-operation): state IDLE, quotient=0, remainder=0, divisor register=0, busy=0, done=0, dz=0. The operation in progress is lost.
- Outputs busy and done are registered: busy=1 in LDB and SUB, done=1 in DONE only.

## Timing
- E0 = clock edge where start=1 is sampled. E1 = next edge (divisor captured).
- Normal case, quotient q: q subtractions on edges E2..E(q+1), failing compare at E(q+2). done rises after E(q+2); latency q+3 edges from E0.
- Divisor zero: done and dz rise after E1. No SUB cycles.
- Dividend < divisor (includes dividend 0): q=0, done after E2.
- Worst case, WIDTH=16, dividend 0xFFFF, divisor 1: done after E65537.
- din is don't-care except at E0 and E1.
- Reset deassertion needs no synchronisation requirement beyond the block. The first start is accepted on the first edge with rst_n=1.

## Test plan
- Divide 100 by 7: din=100 at E0, din=7 at E1.
  - done=1 after E16
  - quotient=14, remainder=2, dz=0
  - busy high from after E0 through E15
- Divide 5 by 9: done after E2, quotient=0, remainder=5.
- Divide 0 by 3: done after E2, quotient=0, remainder=0.
- Divide 42 by 0: done and dz high after E1, quotient=0xFFFF, remainder=42. The next start clears dz.
- Start collisions:
  - pulse start again during SUB of a 1000/1 operation: ignored, result 1000 r 0
  - while done=1, start 9/4: done drops after that edge; result 2 r 1 after E4
- Reset mid-operation: assert rst_n=0 asynchronously, between edges, during SUB of 50/1.
  - all outputs go to 0 immediately
  - state IDLE
  - a following 8/2 operation gives 4 r 0

Source files
------------

// File: rtl/div_repeated_sub_if.sv
// Handshake and data bus between a requester and the repeated-subtraction
// divider. The requester drives start/din; the divider returns the result,
// the busy/done status and the divide-by-zero flag.
interface div_repeated_sub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             dz;

  modport master (
    output start, din,
    input  quotient, remainder, busy, done, dz
  );

  modport slave (
    input  start, din,
    output quotient, remainder, busy, done, dz
  );
endinterface

// File: rtl/div_repeated_sub.sv
// Unsigned divider by repeated subtraction. The dividend and the divisor
// arrive on one shared bus in two consecutive cycles. The divisor is then
// subtracted from the running remainder once per cycle, and the quotient
// counts the subtractions until the remainder drops below the divisor.
// A zero divisor finishes at once with dz set and an all-ones quotient.
module div_repeated_sub #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  div_repeated_sub_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    LDB,
    SUB,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             dz_q;
  logic             busy_q;
  logic             done_q;
  logic             can_sub;

  assign can_sub = (rem_q >= dvs_q);

  // Next-state selection: a start is only honoured when no operation is running
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nx = LDB;
      LDB:        state_nx = (bus.din == '0) ? DONE : SUB;
      SUB:        if (!can_sub) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // State register, with busy/done registered from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx == LDB) || (state_nx == SUB);
      done_q <= (state_nx == DONE);
    end
  end

  // Datapath: load operands, then subtract and count until the remainder is short
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            rem_q <= bus.din;
            quo_q <= '0;
            dz_q  <= 1'b0;
          end
        end
        LDB: begin
          dvs_q <= bus.din;
          if (bus.din == '0) begin
            dz_q  <= 1'b1;
            quo_q <= '1;
          end
        end
        SUB: begin
          if (can_sub) begin
            rem_q <= rem_q - dvs_q;
            quo_q <= quo_q + WIDTH'(1);
          end
        end
        default: begin
          rem_q <= rem_q;
        end
      endcase
    end
  end

  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dz        = dz_q;

endmodule

// File: tb/tb_div_repeated_sub.sv
// Bench for the repeated-subtraction divider: directed cases with literal
// expectations plus randomized operations, all checked every cycle against
// an arithmetic model of the result and of the completion latency.
module tb_div_repeated_sub;

  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int total = 0;
  int bad   = 0;

  div_repeated_sub_if #(.WIDTH(W)) bus ();

  div_repeated_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Model state: edges elapsed since the accepted start (-1 when none in flight)
  int           m_cnt  = -1;
  int           m_lat  = 0;
  logic [W-1:0] m_a    = '0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_q    = '0;
  logic [W-1:0] m_r    = '0;
  logic         m_dz   = 1'b0;

  // Reference model: result from plain division, completion edge from the count
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  = -1;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_q    = '0;
      m_r    = '0;
      m_dz   = 1'b0;
    end else if (m_cnt >= 0) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == 1) begin
        if (bus.din == '0) begin
          m_lat = 1;
          m_q   = '1;
          m_r   = m_a;
          m_dz  = 1'b1;
        end else begin
          m_q   = m_a / bus.din;
          m_r   = m_a % bus.din;
          m_dz  = 1'b0;
          m_lat = int'(m_q) + 2;
        end
      end
      if (m_cnt == m_lat) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_cnt  = -1;
      end
    end else if (bus.start) begin
      m_a    = bus.din;
      m_cnt  = 0;
      m_lat  = 0;
      m_busy = 1'b1;
      m_done = 1'b0;
    end
  end

  // Per-cycle compare of DUT against the model; results only when not busy
  always @(negedge clk) begin
    total++;
    if (bus.busy !== m_busy || bus.done !== m_done) begin
      bad++;
      $display("[TB] FAIL status t=%0t busy=%b done=%b required busy=%b done=%b",
               $time, bus.busy, bus.done, m_busy, m_done);
    end
    if (!m_busy) begin
      total++;
      if (bus.quotient !== m_q || bus.remainder !== m_r || bus.dz !== m_dz) begin
        bad++;
        $display("[TB] FAIL result t=%0t q=%0h r=%0h dz=%b required q=%0h r=%0h dz=%b",
                 $time, bus.quotient, bus.remainder, bus.dz, m_q, m_r, m_dz);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive dividend on E0 and divisor on E1; returns just after E1
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.din   = a;
    @(negedge clk);
    bus.start = 1'b0;
    bus.din   = b;
    @(negedge clk);
    bus.din   = W'($urandom);
  endtask

  // Wait (bounded) for done; edges counts the edge index after E0 where done is seen
  task automatic waitDone(input int budget, output int edges);
    edges = 1;
    while (bus.done !== 1'b1 && edges < budget) begin
      @(negedge clk);
      edges++;
    end
    if (bus.done !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL timeout actual=done_low required=done_high after %0d edges", edges);
    end
  endtask

  // Compare the finished result and model against hand-computed literals
  task automatic checkOutput(input string name, input int q, input int r, input int dz);
    check({name, " quotient"}, int'(bus.quotient), q);
    check({name, " remainder"}, int'(bus.remainder), r);
    check({name, " dz"}, int'(bus.dz), dz);
    check({name, " model_q"}, int'(m_q), q);
    check({name, " model_r"}, int'(m_r), r);
  endtask

  int edges;

  initial begin
    bus.start = 1'b0;
    bus.din   = '0;
    #1 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    $display("[TB] start");

    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset quotient", int'(bus.quotient), 0);

    applyStimulus(16'd100, 16'd7);
    waitDone(100, edges);
    check("100/7 latency", edges, 16);
    checkOutput("100/7", 14, 2, 0);

    applyStimulus(16'd5, 16'd9);
    waitDone(100, edges);
    check("5/9 latency", edges, 2);
    checkOutput("5/9", 0, 5, 0);

    applyStimulus(16'd0, 16'd3);
    waitDone(100, edges);
    check("0/3 latency", edges, 2);
    checkOutput("0/3", 0, 0, 0);

    applyStimulus(16'd42, 16'd0);
    waitDone(100, edges);
    check("42/0 latency", edges, 1);
    checkOutput("42/0", 65535, 42, 1);

    applyStimulus(16'd17, 16'd5);
    waitDone(100, edges);
    checkOutput("17/5 after dz", 3, 2, 0);

    // Start pulses during SUB must be ignored
    applyStimulus(16'd1000, 16'd1);
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    bus.din   = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(1100, edges);
    checkOutput("1000/1 collide", 1000, 0, 0);

    // Start while done: done drops after E0
    @(negedge clk);
    bus.start = 1'b1;
    bus.din   = 16'd9;
    @(negedge clk);
    check("done drop", int'(bus.done), 0);
    bus.start = 1'b0;
    bus.din   = 16'd4;
    @(negedge clk);
    edges = 1;
    waitDone(100, edges);
    check("9/4 latency", edges, 4);
    checkOutput("9/4", 2, 1, 0);

    // Asynchronous reset between edges in the middle of SUB
    applyStimulus(16'd50, 16'd1);
    repeat (8) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset busy", int'(bus.busy), 0);
    check("midreset done", int'(bus.done), 0);
    check("midreset quotient", int'(bus.quotient), 0);
    check("midreset remainder", int'(bus.remainder), 0);
    check("midreset dz", int'(bus.dz), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'd8, 16'd2);
    waitDone(100, edges);
    checkOutput("8/2 after reset", 4, 0, 0);

    // Randomized operations with bounded quotient, some zero divisors
    for (int i = 0; i < 80; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      int qt;
      a  = W'($urandom);
      qt = $urandom_range(0, 250);
      if ($urandom_range(0, 9) == 0) b = '0;
      else b = W'(int'(a) / (qt + 1) + 1);
      if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 40));
      applyStimulus(a, b);
      waitDone(70000 / 64, edges);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
